// File: rtl/intr_ctrl_pkg.sv
// rtl/intr_ctrl_pkg.sv - shared constants for the prioritised interrupt controller
package intr_ctrl_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ASSERT  = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    localparam int N_SRC_DEF = 8;
    localparam int VEC_W_DEF = 3;

endpackage

// File: rtl/intr_prio_enc.sv
// rtl/intr_prio_enc.sv - lowest-index-first priority encoder (index 0 wins)
module intr_prio_enc #(
    parameter int N_SRC = 8,
    parameter int VEC_W = 3
) (
    input  logic [N_SRC-1:0] eligible,
    output logic [VEC_W-1:0] winner,
    output logic             any
);

    always_comb begin
        winner = '0;
        // Scan downwards so the lowest set index is the last assignment.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = VEC_W'(i);
            end
        end
        any = |eligible;
    end

endmodule

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - prioritised interrupt controller with ACK/EOI handshake; INTR_CTRL_EDGE_EN selects edge-latched requests
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int VEC_W = VEC_W_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_SRC-1:0] SRC_REQ,
    input  logic             MASK_WE,
    input  logic [N_SRC-1:0] MASK_WDATA,
    output logic [N_SRC-1:0] MASK_Q,
    output logic             INTR_OUT,
    output logic [VEC_W-1:0] INTR_VEC,
    input  logic             INTR_ACK,
    input  logic             EOI,
    output logic             BUSY
);

    logic [1:0]       state_q,    state_d;
    logic [N_SRC-1:0] pending_q,  pending_d;
    logic [N_SRC-1:0] mask_q,     mask_d;
    logic             intr_out_q, intr_out_d;
    logic [VEC_W-1:0] intr_vec_q, intr_vec_d;
    logic             busy_q,     busy_d;

    logic [N_SRC-1:0] eligible;
    logic [VEC_W-1:0] winner;
    logic             any;
    logic             ack_fire;

    assign eligible = pending_q & ~mask_q;
    assign ack_fire = (state_q == ASSERT) && INTR_ACK;

    intr_prio_enc #(
        .N_SRC (N_SRC),
        .VEC_W (VEC_W)
    ) u_prio_enc (
        .eligible (eligible),
        .winner   (winner),
        .any      (any)
    );

`ifdef INTR_CTRL_EDGE_EN
    logic [N_SRC-1:0] prev_q, prev_d;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;

    always_comb begin
        prev_d    = SRC_REQ;
        rise      = SRC_REQ & ~prev_q;
        clr       = ack_fire ? (N_SRC'(1) << intr_vec_q) : '0;
        // A fresh edge on the acknowledged source survives its own clear.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end
`else
    always_comb begin
        pending_d = SRC_REQ;
    end
`endif

    always_comb begin
        mask_d     = MASK_WE ? MASK_WDATA : mask_q;
        state_d    = state_q;
        intr_out_d = intr_out_q;
        intr_vec_d = intr_vec_q;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    intr_vec_d = winner;
                    intr_out_d = 1'b1;
                    state_d    = ASSERT;
                end
            end
            ASSERT: begin
                if (ack_fire) begin
                    intr_out_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = SERVICE;
                end else if (!eligible[intr_vec_q]) begin
                    intr_out_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            SERVICE: begin
                if (EOI) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                intr_out_d = 1'b0;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            mask_q     <= '1;
            intr_out_q <= 1'b0;
            intr_vec_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            intr_out_q <= intr_out_d;
            intr_vec_q <= intr_vec_d;
            busy_q     <= busy_d;
        end
    end

    assign MASK_Q   = mask_q;
    assign INTR_OUT = intr_out_q;
    assign INTR_VEC = intr_vec_q;
    assign BUSY     = busy_q;

endmodule
